// File: rtl/ahb_ext_sram_ctrl_if.sv
// AHB-Lite external-region bus signals together with the synchronous SRAM port.
// The controller binds the slave modport; the SoC/bench side binds master.
interface ahb_ext_sram_ctrl_if #(
  parameter int AHBW          = 64,
  parameter int PA_BITS       = 34,
  parameter int MEM_ADDR_BITS = 20
);
  logic                     HSELEXT;
  logic [PA_BITS-1:0]       HADDR;
  logic [1:0]               HTRANS;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [AHBW-1:0]          HWDATA;
  logic [AHBW/8-1:0]        HWSTRB;
  logic                     HREADY;
  logic [AHBW-1:0]          HRDATAEXT;
  logic                     HREADYEXT;
  logic                     HRESPEXT;
  logic                     MemCE;
  logic                     MemWE;
  logic [MEM_ADDR_BITS-1:0] MemAddr;
  logic [AHBW-1:0]          MemWData;
  logic [AHBW/8-1:0]        MemBE;
  logic [AHBW-1:0]          MemRData;

  modport slave (
    input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY, MemRData,
    output HRDATAEXT, HREADYEXT, HRESPEXT, MemCE, MemWE, MemAddr, MemWData, MemBE
  );

  modport master (
    output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY, MemRData,
    input  HRDATAEXT, HREADYEXT, HRESPEXT, MemCE, MemWE, MemAddr, MemWData, MemBE
  );
endinterface

// File: rtl/ahb_ext_sram_ctrl.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM with fixed read latency.
// Inserts read/write wait states and answers misaligned or oversize transfers with ERROR.
module ahb_ext_sram_ctrl #(
  parameter int AHBW          = 64,
  parameter int PA_BITS       = 34,
  parameter int MEM_ADDR_BITS = 20,
  parameter int RD_LAT        = 2,
  parameter int WR_WAIT       = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_ext_sram_ctrl_if.slave bus
);
  localparam int OFF   = $clog2(AHBW / 8);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_LAT_C  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_WAIT_C = CNT_W'(WR_WAIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e                   state_q, state_d, acc_state_s;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d, acc_addr_s;
  logic [AHBW-1:0]          hold_q, hold_d;
  logic                     acc_s, err_s, done_s;
  logic                     hready_s, hresp_s, ce_s, we_s;
  logic [AHBW-1:0]          rdata_s, wdata_s;
  logic [AHBW/8-1:0]        be_s;
  logic                     unused_addr_s;

  // A transfer is illegal if wider than the bus or not naturally aligned to its size.
  function automatic logic misaligned(input logic [2:0] size, input logic [OFF-1:0] low);
    logic bad;
    bad = (int'(size) > OFF);
    for (int i = 0; i < OFF; i++) begin
      bad = bad | ((i < int'(size)) & low[i]);
    end
    return bad;
  endfunction

  assign unused_addr_s = ^{bus.HADDR[PA_BITS-1:MEM_ADDR_BITS+OFF], bus.HTRANS[0]};

  // Address-phase decode: classify a candidate transfer and pick the state it would enter.
  always_comb begin
    acc_s       = bus.HSELEXT & bus.HTRANS[1] & bus.HREADY;
    err_s       = misaligned(bus.HSIZE, bus.HADDR[OFF-1:0]);
    acc_addr_s  = bus.HADDR[MEM_ADDR_BITS+OFF-1:OFF];
    acc_state_s = S_IDLE;
    if (!acc_s) begin
      acc_state_s = S_IDLE;
    end else if (err_s) begin
      acc_state_s = S_ERR1;
    end else if (bus.HWRITE) begin
      acc_state_s = S_WR;
    end else begin
      acc_state_s = S_RD;
    end
  end

  // Data-phase control: wait states, SRAM strobes, response and next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    done_s   = 1'b0;
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    rdata_s  = hold_q;
    ce_s     = 1'b0;
    we_s     = 1'b0;
    wdata_s  = {AHBW{1'b0}};
    be_s     = {(AHBW/8){1'b0}};
    case (state_q)
      S_IDLE: done_s = 1'b1;
      S_RD: begin
        ce_s = (cnt_q == {CNT_W{1'b0}});
        if (cnt_q == RD_LAT_C) begin
          done_s  = 1'b1;
          rdata_s = bus.MemRData;
          hold_d  = bus.MemRData;
        end else begin
          hready_s = 1'b0;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      S_WR: begin
        if (cnt_q == WR_WAIT_C) begin
          done_s  = 1'b1;
          ce_s    = 1'b1;
          we_s    = 1'b1;
          wdata_s = bus.HWDATA;
          be_s    = bus.HWSTRB;
        end else begin
          hready_s = 1'b0;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      S_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 1'b1;
        state_d  = S_ERR2;
      end
      S_ERR2: begin
        hresp_s = 1'b1;
        done_s  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Completion cycles may accept the next transfer directly, with no IDLE bubble.
    if (done_s) begin
      state_d = acc_state_s;
      cnt_d   = {CNT_W{1'b0}};
      addr_d  = acc_s ? acc_addr_s : addr_q;
    end else begin
      addr_d  = addr_q;
    end
  end

  // State, wait counter, captured address and read-data hold register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {MEM_ADDR_BITS{1'b0}};
      hold_q  <= {AHBW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.HREADYEXT = hready_s;
  assign bus.HRESPEXT  = hresp_s;
  assign bus.HRDATAEXT = rdata_s;
  assign bus.MemCE     = ce_s;
  assign bus.MemWE     = we_s;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWData  = wdata_s;
  assign bus.MemBE     = be_s;
endmodule

// File: tb/tb_ahb_ext_sram_ctrl.sv
// Directed bench for ahb_ext_sram_ctrl with RD_LAT=2, WR_WAIT=1 on a 64-bit bus.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ahb_ext_sram_ctrl;
  localparam int AHBW = 64, PA_BITS = 34, MEM_ADDR_BITS = 20, RD_LAT = 2, WR_WAIT = 1;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  ahb_ext_sram_ctrl_if #(.AHBW(AHBW), .PA_BITS(PA_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS)) bus ();

  ahb_ext_sram_ctrl #(
    .AHBW(AHBW), .PA_BITS(PA_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS),
    .RD_LAT(RD_LAT), .WR_WAIT(WR_WAIT)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  // Single-subordinate system: the global HREADY follows this subordinate.
  assign bus.HREADY = bus.HREADYEXT;

  // {HREADYEXT, HRESPEXT, MemCE, MemWE}
  logic [3:0] st;
  assign st = {bus.HREADYEXT, bus.HRESPEXT, bus.MemCE, bus.MemWE};

  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic idle_bus();
    bus.HSELEXT = 1'b0;
    bus.HTRANS  = 2'b00;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'd0;
    bus.HADDR   = 34'h0;
    bus.HWDATA  = 64'h0;
    bus.HWSTRB  = 8'h00;
  endtask

  task automatic addr_phase(input logic wr, input logic [33:0] a, input logic [2:0] sz);
    bus.HSELEXT = 1'b1;
    bus.HTRANS  = 2'b10;
    bus.HWRITE  = wr;
    bus.HADDR   = a;
    bus.HSIZE   = sz;
  endtask

  task automatic test_reset();
    idle_bus();
    bus.MemRData = 64'h5555_5555_5555_5555;
    HRESETn = 1'b0;
    next_cyc();
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL reset_st: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'h0) begin err_cnt++; $display("FAIL reset_rdata: got %h exp %h", bus.HRDATAEXT, 64'h0); end
    next_cyc();
    HRESETn = 1'b1;
    smp();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      bus.HSELEXT = (i < 3) ? 1'b1 : 1'b0;
      bus.HTRANS  = (i < 3) ? ((i == 1) ? 2'b01 : 2'b00) : 2'b10;
      bus.HADDR   = 34'h0_0000_0040;
      bus.HSIZE   = 3'd3;
      smp();
      vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL idle_st[%0d]: got %b exp %b", i, st, 4'b1000); end
    end
    next_cyc();
    idle_bus();
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL idle_after: got %b exp %b", st, 4'b1000); end
  endtask

  task automatic test_read();
    next_cyc();
    addr_phase(1'b0, 34'h0_8000_0010, 3'd3);
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL rd_a0: got %b exp %b", st, 4'b1000); end
    next_cyc();
    bus.HSELEXT = 1'b0;
    bus.HTRANS  = 2'b00;
    smp();
    vec_cnt++; if (st !== 4'b0010) begin err_cnt++; $display("FAIL rd_a1_st: got %b exp %b", st, 4'b0010); end
    vec_cnt++; if (bus.MemAddr !== 20'h00002) begin err_cnt++; $display("FAIL rd_a1_addr: got %h exp %h", bus.MemAddr, 20'h00002); end
    next_cyc();
    smp();
    vec_cnt++; if (st !== 4'b0000) begin err_cnt++; $display("FAIL rd_a2_st: got %b exp %b", st, 4'b0000); end
    next_cyc();
    bus.MemRData = 64'hDEAD_BEEF_0123_4567;
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL rd_a3_st: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'hDEAD_BEEF_0123_4567) begin err_cnt++; $display("FAIL rd_a3_data: got %h exp %h", bus.HRDATAEXT, 64'hDEAD_BEEF_0123_4567); end
    next_cyc();
    bus.MemRData = 64'hA5A5_A5A5_A5A5_A5A5;
    smp();
    vec_cnt++; if (bus.HRDATAEXT !== 64'hDEAD_BEEF_0123_4567) begin err_cnt++; $display("FAIL rd_hold: got %h exp %h", bus.HRDATAEXT, 64'hDEAD_BEEF_0123_4567); end
  endtask

  task automatic test_write();
    next_cyc();
    addr_phase(1'b1, 34'h0_0000_0008, 3'd2);
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL wr_a0: got %b exp %b", st, 4'b1000); end
    next_cyc();
    bus.HTRANS = 2'b00;
    bus.HWDATA = 64'h1122_3344_5566_7788;
    bus.HWSTRB = 8'hF0;
    smp();
    vec_cnt++; if (st !== 4'b0000) begin err_cnt++; $display("FAIL wr_wait: got %b exp %b", st, 4'b0000); end
    next_cyc();
    smp();
    vec_cnt++; if (st !== 4'b1011) begin err_cnt++; $display("FAIL wr_done_st: got %b exp %b", st, 4'b1011); end
    vec_cnt++; if (bus.MemAddr !== 20'h00001) begin err_cnt++; $display("FAIL wr_addr: got %h exp %h", bus.MemAddr, 20'h00001); end
    vec_cnt++; if (bus.MemBE !== 8'hF0) begin err_cnt++; $display("FAIL wr_be: got %h exp %h", bus.MemBE, 8'hF0); end
    vec_cnt++; if (bus.MemWData !== 64'h1122_3344_5566_7788) begin err_cnt++; $display("FAIL wr_wdata: got %h exp %h", bus.MemWData, 64'h1122_3344_5566_7788); end
    next_cyc();
    idle_bus();
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL wr_after: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'hDEAD_BEEF_0123_4567) begin err_cnt++; $display("FAIL wr_hold: got %h exp %h", bus.HRDATAEXT, 64'hDEAD_BEEF_0123_4567); end
  endtask

  task automatic test_error();
    logic [33:0] ea [3];
    logic [2:0]  es [3];
    ea[0] = 34'h0_0000_0003; es[0] = 3'd2;
    ea[1] = 34'h0_0000_0000; es[1] = 3'd4;
    ea[2] = 34'h0_0000_0004; es[2] = 3'd3;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      addr_phase(1'b0, ea[k], es[k]);
      smp();
      vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL err%0d_a0: got %b exp %b", k, st, 4'b1000); end
      next_cyc();
      bus.HTRANS = 2'b00;
      smp();
      vec_cnt++; if (st !== 4'b0100) begin err_cnt++; $display("FAIL err%0d_err1: got %b exp %b", k, st, 4'b0100); end
      next_cyc();
      smp();
      vec_cnt++; if (st !== 4'b1100) begin err_cnt++; $display("FAIL err%0d_err2: got %b exp %b", k, st, 4'b1100); end
      next_cyc();
      smp();
      vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL err%0d_idle: got %b exp %b", k, st, 4'b1000); end
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    next_cyc();
    addr_phase(1'b1, 34'h0_0000_0010, 3'd3);
    smp();
    next_cyc();
    bus.HTRANS = 2'b00;
    bus.HWDATA = 64'h0F0E_0D0C_0B0A_0908;
    bus.HWSTRB = 8'hFF;
    smp();
    vec_cnt++; if (st !== 4'b0000) begin err_cnt++; $display("FAIL b2b_wwait: got %b exp %b", st, 4'b0000); end
    next_cyc();
    addr_phase(1'b0, 34'h0_0000_0018, 3'd3);
    smp();
    vec_cnt++; if (st !== 4'b1011) begin err_cnt++; $display("FAIL b2b_wdone: got %b exp %b", st, 4'b1011); end
    vec_cnt++; if (bus.MemAddr !== 20'h00002) begin err_cnt++; $display("FAIL b2b_waddr: got %h exp %h", bus.MemAddr, 20'h00002); end
    vec_cnt++; if (bus.MemWData !== 64'h0F0E_0D0C_0B0A_0908) begin err_cnt++; $display("FAIL b2b_wdata: got %h exp %h", bus.MemWData, 64'h0F0E_0D0C_0B0A_0908); end
    next_cyc();
    bus.HTRANS = 2'b00;
    smp();
    vec_cnt++; if (st !== 4'b0010) begin err_cnt++; $display("FAIL b2b_rce: got %b exp %b", st, 4'b0010); end
    vec_cnt++; if (bus.MemAddr !== 20'h00003) begin err_cnt++; $display("FAIL b2b_raddr: got %h exp %h", bus.MemAddr, 20'h00003); end
    next_cyc();
    smp();
    vec_cnt++; if (st !== 4'b0000) begin err_cnt++; $display("FAIL b2b_rwait: got %b exp %b", st, 4'b0000); end
    next_cyc();
    bus.MemRData = 64'h1111_2222_3333_4444;
    addr_phase(1'b0, 34'h0_0000_0020, 3'd3);
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL b2b_rdone: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'h1111_2222_3333_4444) begin err_cnt++; $display("FAIL b2b_rdata: got %h exp %h", bus.HRDATAEXT, 64'h1111_2222_3333_4444); end
    next_cyc();
    bus.HTRANS = 2'b00;
    bus.MemRData = 64'h0;
    smp();
    vec_cnt++; if (st !== 4'b0010) begin err_cnt++; $display("FAIL b2b_r2ce: got %b exp %b", st, 4'b0010); end
    vec_cnt++; if (bus.MemAddr !== 20'h00004) begin err_cnt++; $display("FAIL b2b_r2addr: got %h exp %h", bus.MemAddr, 20'h00004); end
    next_cyc();
    smp();
    next_cyc();
    bus.MemRData = 64'h7777_8888_9999_AAAA;
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL b2b_r2done: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'h7777_8888_9999_AAAA) begin err_cnt++; $display("FAIL b2b_r2data: got %h exp %h", bus.HRDATAEXT, 64'h7777_8888_9999_AAAA); end
    next_cyc();
    idle_bus();
    smp();
  endtask

  task automatic test_reset_mid();
    next_cyc();
    addr_phase(1'b0, 34'h0_0000_0028, 3'd3);
    smp();
    next_cyc();
    bus.HTRANS = 2'b00;
    smp();
    vec_cnt++; if (st !== 4'b0010) begin err_cnt++; $display("FAIL rst_mid_ce: got %b exp %b", st, 4'b0010); end
    next_cyc();
    HRESETn = 1'b0;
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL rst_mid_st: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'h0) begin err_cnt++; $display("FAIL rst_mid_rdata: got %h exp %h", bus.HRDATAEXT, 64'h0); end
    next_cyc();
    bus.MemRData = 64'hCAFE_F00D_CAFE_F00D;
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL rst_hold_st: got %b exp %b", st, 4'b1000); end
    next_cyc();
    HRESETn = 1'b1;
    idle_bus();
    smp();
    vec_cnt++; if (st !== 4'b1000) begin err_cnt++; $display("FAIL rst_rel_st: got %b exp %b", st, 4'b1000); end
    vec_cnt++; if (bus.HRDATAEXT !== 64'h0) begin err_cnt++; $display("FAIL rst_rel_rdata: got %h exp %h", bus.HRDATAEXT, 64'h0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_read();
    test_write();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
